demux_unstriping: RTL and testbench
===================================

# demux_unstriping

Receive-side counterpart of the lane striping multiplexer. It takes the single interleaved word stream on `clk_2f` and splits it back into two lanes. Even-position words go to lane 0 and odd-position words go to lane 1. Each lane-0 word is held until its lane-1 partner arrives, so both lanes are presented together as an aligned pair, valid for one `clk_f`-equivalent period (two `clk_2f` cycles). The block sits between the serial-to-parallel/byte-unstriping path and the per-lane downstream logic.

## Interface

**Parameters**
- `WIDTH`, default 32: word width of the input stream and of each lane.

**Ports**
- `clk_2f`, input, 1: clock; `clk_2f` is the clock, double-rate relative to lane rate.
- `reset`, input, 1: reset; synchronous, active-low.
- `data_input`, input, WIDTH: interleaved word stream.
- `valid_in`, input, 1: `data_input` carries a word this cycle.
- `lane_0`, output, WIDTH: lane-0 word of the current pair (registered).
- `lane_1`, output, WIDTH: lane-1 word of the current pair (registered).
- `valid_0`, output, 1: `lane_0` valid.
- `valid_1`, output, 1: `lane_1` valid; always equal to `valid_0`.
- `pair_pending`, output, 1: a lane-0 word is held and waiting for its lane-1 partner.

## Operation

**Reset** (`reset == 0` at a rising edge of `clk_2f`) clears all registers:
- sel = EVEN;
- hold_0 = 0;
- `lane_0` = 0, `lane_1` = 0;
- `valid_0` = 0, `valid_1` = 0;
- `pair_pending` = 0;
- hold counter = 0.

Reset has priority over all other activity. Asserting it mid-pair discards the held word, and the next accepted word is treated as a lane-0 word.

**Lane-select state machine `sel`** has two states:
- **EVEN, `valid_in == 1`:**
  - hold_0 <= `data_input`;
  - `pair_pending` <= 1;
  - sel -> ODD.
- **EVEN, `valid_in == 0`:** no change.
- **ODD, `valid_in == 1`:** emit a pair:
  - `lane_0` <= hold_0;
  - `lane_1` <= `data_input`;
  - `valid_0` = `valid_1` <= 1;
  - hold counter <= 1;
  - `pair_pending` <= 0;
  - sel -> EVEN.
- **ODD, `valid_in == 0`:** no change. The held word is kept for as long as the gap lasts.

**Lane assignment**
- Gaps in `valid_in` never change lane assignment. Parity is set only by the count of accepted words since reset, mirroring the transmit multiplexer, which stalls on the expected lane.
- There is no timeout and no flush. A lone lane-0 word waits indefinitely.

**Output valid window**
- On a cycle with no emission:
  - if the hold counter is 1, it goes to 0 and the valids stay at 1;
  - if the hold counter is 0, the valids go to 0.
- An emission always reloads the window (hold counter <= 1), so back-to-back pairs keep the valids continuously high.
- `lane_0` and `lane_1` keep their last values when the valids are low. They are not cleared.

**Invariant:** `valid_0 == valid_1` at all times. There are no partial pairs on the outputs.

## Timing

- **Pair latency:**
  - The lane-1 word is sampled at edge k.
  - The pair is visible on the outputs after edge k with valids at 1.
  - The lane-0 word's latency equals the distance from its own sampling edge to edge k.
- **Valid window:** a pair emitted at edge k is valid after edges k and k+1. The valids drop after edge k+2, unless another pair is emitted at edge k+2.
- **Minimum spacing:** consecutive emissions are at least 2 cycles apart, because a pair needs 2 accepted words. Window reload therefore never cuts a pair's window short.
- **`pair_pending`:**
  - rises after the edge that accepts a lane-0 word;
  - falls after the edge that emits the pair.
- **Throughput:** the block accepts one word per cycle with no backpressure. `valid_in` may be high every cycle.

## Test plan

1. **Reset.** Hold `reset=0` for 3 cycles with `valid_in=1`.
   - Required: all outputs are 0 and sel = EVEN.
   - After release, the first word goes to lane 0.
2. **Continuous stream.** Send `0xA0`, `0xB1`, `0xA2`, `0xB3` on edges 1–4.
   - Required: after edge 2, `lane_0`/`lane_1` = `0xA0`/`0xB1`.
   - After edge 4, they are `0xA2`/`0xB3`.
   - The valids stay high continuously from edge 2 through edge 5 and drop after edge 6.
   - `pair_pending` is high after edges 1 and 3 only.
3. **Gap mid-pair.** Send `0x11` at edge 1, then `valid_in=0` for 5 cycles, then `0x22`.
   - Required: `pair_pending=1` throughout the gap and the valids stay 0.
   - After the edge that samples `0x22`, the outputs are `0x11`/`0x22` with valids high for 2 cycles.
4. **Gap between pairs.** Send a pair, idle for 4 cycles, then send another pair.
   - Required: each pair gets exactly a 2-cycle valid window.
   - The outputs hold the old data while the valids are low.
   - Lane parity is preserved (the third word lands on lane 0).
5. **Reset mid-pair.** Send `0x33`, assert reset for 1 cycle, then send `0x44`, `0x55`.
   - Required: `0x33` is discarded; the emitted pair is `0x44`/`0x55`.
6. **Loopback.** Drive two lanes through the striping multiplexer into this block, using random valid patterns and 200 words.
   - Required: lane outputs equal the original lane sequences in order, with `valid_0 == valid_1` at all times.

Source files
------------

// File: rtl/demux_unstriping_if.sv
// Bundles the interleaved input stream and the aligned two-lane output pair
// of the unstriping demultiplexer.
interface demux_unstriping_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_input;
    logic             valid_in;
    logic [WIDTH-1:0] lane_0;
    logic [WIDTH-1:0] lane_1;
    logic             valid_0;
    logic             valid_1;
    logic             pair_pending;

    // Upstream side: drives the word stream and observes the lane pair.
    modport master (
        output data_input,
        output valid_in,
        input  lane_0,
        input  lane_1,
        input  valid_0,
        input  valid_1,
        input  pair_pending
    );

    // Demultiplexer side: consumes the word stream and produces the lane pair.
    modport slave (
        input  data_input,
        input  valid_in,
        output lane_0,
        output lane_1,
        output valid_0,
        output valid_1,
        output pair_pending
    );
endinterface

// File: rtl/demux_unstriping.sv
// Splits an interleaved word stream on clk_2f back into two lanes. Even
// words are held until their odd partner arrives, then both are presented
// together as an aligned pair with a two-cycle valid window.
module demux_unstriping #(
    parameter int WIDTH = 32
) (
    input  logic               clk_2f,
    input  logic               reset,
    demux_unstriping_if.slave  bus
);
    typedef enum logic {
        EVEN = 1'b0,
        ODD  = 1'b1
    } sel_t;

    sel_t             sel_reg;
    logic [WIDTH-1:0] hold_0_reg;
    logic [WIDTH-1:0] lane_0_reg;
    logic [WIDTH-1:0] lane_1_reg;
    logic             valid_reg;
    logic             pending_reg;
    logic             hold_cnt_reg;

    // Lane-select FSM, held-word register and output valid window. A single
    // valid register feeds both lane valids so they can never disagree.
    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            sel_reg      <= EVEN;
            hold_0_reg   <= '0;
            lane_0_reg   <= '0;
            lane_1_reg   <= '0;
            valid_reg    <= 1'b0;
            pending_reg  <= 1'b0;
            hold_cnt_reg <= 1'b0;
        end else if (sel_reg == ODD && bus.valid_in) begin
            // Partner word arrived: emit the pair and reload the window.
            lane_0_reg   <= hold_0_reg;
            lane_1_reg   <= bus.data_input;
            valid_reg    <= 1'b1;
            hold_cnt_reg <= 1'b1;
            pending_reg  <= 1'b0;
            sel_reg      <= EVEN;
        end else begin
            if (sel_reg == EVEN && bus.valid_in) begin
                hold_0_reg  <= bus.data_input;
                pending_reg <= 1'b1;
                sel_reg     <= ODD;
            end
            // No emission this cycle: run down the valid window.
            if (hold_cnt_reg) begin
                hold_cnt_reg <= 1'b0;
            end else begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign bus.lane_0       = lane_0_reg;
    assign bus.lane_1       = lane_1_reg;
    assign bus.valid_0      = valid_reg;
    assign bus.valid_1      = valid_reg;
    assign bus.pair_pending = pending_reg;
endmodule

// File: tb/tb_demux_unstriping.sv
// Directed and loopback bench for demux_unstriping. Expected pairs are
// queued when the lane-1 word is driven and popped when the pair is due.
module tb_demux_unstriping;
    localparam int WIDTH = 32;

    logic clk_2f = 1'b0;
    logic reset  = 1'b0;

    demux_unstriping_if #(.WIDTH(WIDTH)) bus ();

    demux_unstriping #(.WIDTH(WIDTH)) dut (
        .clk_2f (clk_2f),
        .reset  (reset),
        .bus    (bus.slave)
    );

    always #5 clk_2f = ~clk_2f;

    int n_total = 0;
    int n_pass  = 0;

    // Reference state kept by the bench
    logic             par     = 1'b0;
    logic [WIDTH-1:0] hw      = '0;
    logic             pend    = 1'b0;
    int               age     = 2;
    logic [WIDTH-1:0] el0     = '0;
    logic [WIDTH-1:0] el1     = '0;
    logic [2*WIDTH-1:0] sb[$];

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Drive one cycle, advance the reference, then check every output.
    task automatic step(input logic rst_n, input logic v, input logic [WIDTH-1:0] d);
        logic               emit;
        logic [2*WIDTH-1:0] pr;
        emit = 1'b0;
        reset          = rst_n;
        bus.valid_in   = v;
        bus.data_input = d;
        if (rst_n && v && par) sb.push_back({hw, d});
        @(posedge clk_2f);
        #1;
        if (!rst_n) begin
            par = 1'b0; hw = '0; pend = 1'b0; age = 2; el0 = '0; el1 = '0;
            sb.delete();
        end else if (v) begin
            if (!par) begin
                hw = d; par = 1'b1; pend = 1'b1;
                if (age < 2) age++;
            end else begin
                par = 1'b0; pend = 1'b0; age = 0; emit = 1'b1;
            end
        end else begin
            if (age < 2) age++;
        end
        if (emit) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                pr  = sb.pop_front();
                el0 = pr[2*WIDTH-1:WIDTH];
                el1 = pr[WIDTH-1:0];
            end
        end
        chk("valid_0", {31'd0, bus.valid_0}, {31'd0, (age <= 1)});
        chk("valid_1", {31'd0, bus.valid_1}, {31'd0, (age <= 1)});
        chk("pair_pending", {31'd0, bus.pair_pending}, {31'd0, pend});
        chk("lane_0", bus.lane_0, el0);
        chk("lane_1", bus.lane_1, el1);
        $display("t=%0t rst_n=%0b v=%0b d=%h -> l0=%h l1=%h v0=%0b v1=%0b pend=%0b",
                 $time, rst_n, v, d, bus.lane_0, bus.lane_1,
                 bus.valid_0, bus.valid_1, bus.pair_pending);
    endtask

    logic [WIDTH-1:0] seq0[100];
    logic [WIDTH-1:0] seq1[100];

    initial begin
        bus.valid_in   = 1'b0;
        bus.data_input = '0;

        // 1. Reset held with valid_in high
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'hDEAD_0000 + i);

        // 2. Continuous stream, then idle to see the window close
        step(1'b1, 1'b1, 32'hA0);
        step(1'b1, 1'b1, 32'hB1);
        step(1'b1, 1'b1, 32'hA2);
        step(1'b1, 1'b1, 32'hB3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // 3. Gap mid-pair
        step(1'b1, 1'b1, 32'h11);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 32'h22);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // 4. Gap between pairs; the third word must land on lane 0
        step(1'b1, 1'b1, 32'hC0);
        step(1'b1, 1'b1, 32'hC1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'hC2);
        step(1'b1, 1'b1, 32'hC3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // 5. Reset mid-pair discards the held word
        step(1'b1, 1'b1, 32'h33);
        step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h44);
        step(1'b1, 1'b1, 32'h55);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // 6. Loopback: two lane sequences interleaved with random gaps
        for (int i = 0; i < 100; i++) begin
            seq0[i] = $urandom;
            seq1[i] = $urandom;
        end
        for (int i = 0; i < 100; i++) begin
            while ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, $urandom);
            step(1'b1, 1'b1, seq0[i]);
            while ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, $urandom);
            step(1'b1, 1'b1, seq1[i]);
            chk("loop_lane_0", bus.lane_0, seq0[i]);
            chk("loop_lane_1", bus.lane_1, seq1[i]);
        end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
